// File: rtl/pixel_ray_scheduler_pkg.sv
// Shared types and constants for the pixel ray scheduler: FSM states,
// default screen size, coordinate/direction widths and the packed
// records carried by the tag and result FIFOs.
package pixel_sched_pkg;

    localparam int DEF_WIDTH  = 512;
    localparam int DEF_HEIGHT = 384;

    localparam int PIX_X_W = 11;
    localparam int PIX_Y_W = 10;
    localparam int DIR_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_e;

    // Pixel coordinate travelling alongside its in-flight ray.
    typedef struct packed {
        logic [PIX_X_W-1:0] x;
        logic [PIX_Y_W-1:0] y;
    } ray_tag_t;

    // Direction vector returned by the direction pipeline.
    typedef struct packed {
        logic [DIR_W-1:0] dx;
        logic [DIR_W-1:0] dy;
        logic [DIR_W-1:0] dz;
    } ray_dir_t;

    function automatic ray_tag_t make_tag(input logic [PIX_X_W-1:0] x,
                                          input logic [PIX_Y_W-1:0] y);
        ray_tag_t t;
        t.x = x;
        t.y = y;
        return t;
    endfunction

endpackage

// File: rtl/pixel_ray_scheduler_if.sv
// Valid/ready ray stream bundle: pixel coordinate plus float32 direction.
interface ray_stream_if;
    logic        valid;
    logic        ready;
    logic [10:0] x;
    logic [9:0]  y;
    logic [31:0] dir_x;
    logic [31:0] dir_y;
    logic [31:0] dir_z;

    modport master (output valid, x, y, dir_x, dir_y, dir_z, input ready);
    modport slave  (input valid, x, y, dir_x, dir_y, dir_z, output ready);
endinterface

// File: rtl/pixel_ray_scheduler_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. Storage is a plain array so it
// can map onto RAM; the head word is held in an output register that is
// loaded with the next-cycle head (or the incoming word when the FIFO is
// about to go from empty to one entry).
module sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   push_in,
    input  logic [DW-1:0]          din_in,
    input  logic                   pop_in,
    output logic [DW-1:0]          dout_out,
    output logic                   full_out,
    output logic                   empty_out,
    output logic [$clog2(DEPTH):0] count_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d, count_after_pop;
    logic [DW-1:0] dout_q, dout_d;
    logic          full_q, empty_q;
    logic          do_push, do_pop;

    assign do_push = push_in && !full_q;
    assign do_pop  = pop_in && !empty_q;

    // Next pointers, occupancy and the word that will sit at the head.
    always_comb begin
        rd_ptr_d        = rd_ptr_q + AW'(do_pop);
        count_after_pop = count_q - CW'(do_pop);
        count_d         = count_after_pop + CW'(do_push);
        dout_d          = dout_q;
        if (do_push && count_after_pop == '0) begin
            dout_d = din_in;
        end else if (count_after_pop != '0) begin
            dout_d = mem[rd_ptr_d];
        end
    end

    // Storage array write port, no reset so it can live in RAM.
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din_in;
        end
    end

    // Pointers, flags and registered head word.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(do_push);
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CW'(DEPTH));
            empty_q  <= (count_d == '0);
            dout_q   <= dout_d;
        end
    end

    assign dout_out  = dout_q;
    assign full_out  = full_q;
    assign empty_out = empty_q;
    assign count_out = count_q;
endmodule

// File: rtl/pixel_ray_scheduler.sv
// Raster-order pixel issuer for a fixed-latency direction pipeline.
// Credits bound the rays in flight; each issued coordinate waits in a tag
// FIFO until its direction returns into the result FIFO, and both heads
// are presented together on a valid/ready ray stream.
module pixel_ray_scheduler
    import pixel_sched_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int HEIGHT  = DEF_HEIGHT,
    parameter int CREDITS = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    output logic        busy_out,
    output logic        frame_done_out,
    output logic [10:0] pix_x_out,
    output logic [9:0]  pix_y_out,
    output logic        pix_valid_out,
    input  logic [31:0] dir_x_in,
    input  logic [31:0] dir_y_in,
    input  logic [31:0] dir_z_in,
    input  logic        dir_valid_in,
    output logic [10:0] ray_x_out,
    output logic [9:0]  ray_y_out,
    output logic [31:0] ray_dir_x_out,
    output logic [31:0] ray_dir_y_out,
    output logic [31:0] ray_dir_z_out,
    output logic        ray_valid_out,
    input  logic        ray_ready_in,
    output logic        ovf_err_out
);
    localparam int OW = $clog2(CREDITS) + 1;
    localparam logic [PIX_X_W-1:0] X_LAST = PIX_X_W'(WIDTH - 1);
    localparam logic [PIX_Y_W-1:0] Y_LAST = PIX_Y_W'(HEIGHT - 1);
    localparam logic [OW-1:0]      CRED   = OW'(CREDITS);

    sched_state_e       state_q;
    logic               busy_q, frame_done_q, pix_valid_q, ovf_q;
    logic [PIX_X_W-1:0] pix_x_q;
    logic [PIX_Y_W-1:0] pix_y_q;
    logic [OW-1:0]      out_q, out_d;

    logic               issue, pop, last_pix, stray, res_push;
    ray_tag_t           tag_head;
    ray_dir_t           dir_head, dir_in;
    logic               tag_full, tag_empty, res_full, res_empty;
    logic [OW-1:0]      tag_count, res_count;
    logic               unused_tag_flags;

    // An issue happens in every cycle the registered strobe is high.
    assign issue    = pix_valid_q;
    assign pop      = ray_valid_out && ray_ready_in;
    assign last_pix = (pix_x_q == X_LAST) && (pix_y_q == Y_LAST);

    // A result is stray if there is nowhere to put it or no tag waiting for it.
    assign stray    = dir_valid_in && (res_full || (tag_count <= res_count));
    assign res_push = dir_valid_in && !stray;
    assign dir_in   = '{dx: dir_x_in, dy: dir_y_in, dz: dir_z_in};

    // Outstanding rays: issue adds one, handshake removes one.
    always_comb begin
        out_d = out_q;
        case ({issue, pop})
            2'b10:   out_d = out_q + OW'(1);
            2'b01:   out_d = out_q - OW'(1);
            default: out_d = out_q;
        endcase
    end

    // Outstanding counter register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    // Frame FSM with registered strobes and raster coordinate counters.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_in) begin
                        state_q     <= ST_ISSUE;
                        busy_q      <= 1'b1;
                        pix_valid_q <= (out_d < CRED);
                        pix_x_q     <= '0;
                        pix_y_q     <= '0;
                    end
                end
                ST_ISSUE: begin
                    pix_valid_q <= (out_d < CRED);
                    if (issue) begin
                        if (last_pix) begin
                            state_q     <= ST_DRAIN;
                            pix_valid_q <= 1'b0;
                            pix_x_q     <= '0;
                            pix_y_q     <= '0;
                        end else if (pix_x_q == X_LAST) begin
                            pix_x_q <= '0;
                            pix_y_q <= pix_y_q + PIX_Y_W'(1);
                        end else begin
                            pix_x_q <= pix_x_q + PIX_X_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    pix_valid_q <= 1'b0;
                    if (out_d == '0) begin
                        state_q      <= ST_IDLE;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    pix_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Sticky protocol-error flag for discarded results.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ovf_q <= 1'b0;
        end else if (stray) begin
            ovf_q <= 1'b1;
        end
    end

    sync_fifo #(.DW($bits(ray_tag_t)), .DEPTH(CREDITS)) u_tag_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push_in   (issue),
        .din_in    (make_tag(pix_x_q, pix_y_q)),
        .pop_in    (pop),
        .dout_out  (tag_head),
        .full_out  (tag_full),
        .empty_out (tag_empty),
        .count_out (tag_count)
    );

    sync_fifo #(.DW($bits(ray_dir_t)), .DEPTH(CREDITS)) u_res_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push_in   (res_push),
        .din_in    (dir_in),
        .pop_in    (pop),
        .dout_out  (dir_head),
        .full_out  (res_full),
        .empty_out (res_empty),
        .count_out (res_count)
    );

    // Tag occupancy is tracked through its count; the flags are not needed.
    assign unused_tag_flags = tag_full ^ tag_empty;

    assign busy_out       = busy_q;
    assign frame_done_out = frame_done_q;
    assign pix_valid_out  = pix_valid_q;
    assign pix_x_out      = pix_x_q;
    assign pix_y_out      = pix_y_q;
    assign ovf_err_out    = ovf_q;
    assign ray_valid_out  = !res_empty;
    assign ray_x_out      = tag_head.x;
    assign ray_y_out      = tag_head.y;
    assign ray_dir_x_out  = dir_head.dx;
    assign ray_dir_y_out  = dir_head.dy;
    assign ray_dir_z_out  = dir_head.dz;
endmodule

// File: tb/tb_pixel_ray_scheduler.sv
// Bench for pixel_ray_scheduler on a 4x2 frame with 4 credits and a
// latency-10 direction pipeline returning float(x), float(y) and a
// coordinate signature in dir_z.
module tb_pixel_ray_scheduler;
    localparam int W   = 4;
    localparam int H   = 2;
    localparam int C   = 4;
    localparam int LAT = 10;

    logic        clk = 1'b0;
    logic        rst, start, dir_valid;
    logic [31:0] dir_x, dir_y, dir_z;
    logic        busy_out, frame_done_out, pix_valid_out, ovf_err_out;
    logic [10:0] pix_x_out;
    logic [9:0]  pix_y_out;

    ray_stream_if rif();

    pixel_ray_scheduler #(.WIDTH(W), .HEIGHT(H), .CREDITS(C)) dut (
        .clk_in(clk), .rst_in(rst), .start_in(start),
        .busy_out(busy_out), .frame_done_out(frame_done_out),
        .pix_x_out(pix_x_out), .pix_y_out(pix_y_out), .pix_valid_out(pix_valid_out),
        .dir_x_in(dir_x), .dir_y_in(dir_y), .dir_z_in(dir_z), .dir_valid_in(dir_valid),
        .ray_x_out(rif.x), .ray_y_out(rif.y),
        .ray_dir_x_out(rif.dir_x), .ray_dir_y_out(rif.dir_y), .ray_dir_z_out(rif.dir_z),
        .ray_valid_out(rif.valid), .ray_ready_in(rif.ready),
        .ovf_err_out(ovf_err_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // IEEE-754 single-precision encodings of the small integers used here.
    function automatic logic [31:0] fbits(input int v);
        case (v)
            0: return 32'h0000_0000;
            1: return 32'h3F80_0000;
            2: return 32'h4000_0000;
            3: return 32'h4040_0000;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] dirz(input int x, input int y);
        return 32'hC0DE_0000 | 32'(y << 8) | 32'(x);
    endfunction

    // Direction pipeline model: fixed latency, in order, flushed by reset.
    logic pv [LAT];
    int   px [LAT];
    int   py [LAT];
    bit   inj = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; px[i] = 0; py[i] = 0; end
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin pv[i] = pv[i-1]; px[i] = px[i-1]; py[i] = py[i-1]; end
            pv[0] = pix_valid_out;
            px[0] = int'(pix_x_out);
            py[0] = int'(pix_y_out);
        end
        dir_valid = pv[LAT-1] | inj;
        dir_x     = fbits(px[LAT-1]);
        dir_y     = fbits(py[LAT-1]);
        dir_z     = dirz(px[LAT-1], py[LAT-1]);
    end

    // Stream monitor: collects handshakes, counts strobes, checks hold-stability.
    int          pix_cnt = 0, done_cnt = 0, stall_checks = 0;
    int          obs_x[$], obs_y[$];
    logic [31:0] obs_dx[$], obs_dy[$], obs_dz[$];
    bit          stall_prev = 1'b0;
    logic [116:0] prev_ray;

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (pix_valid_out) pix_cnt++;
            if (frame_done_out) done_cnt++;
            if (stall_prev) begin
                checks++;
                stall_checks++;
                if ({rif.valid, rif.x, rif.y, rif.dir_x, rif.dir_y, rif.dir_z} !== {1'b1, prev_ray})
                    begin
                    errors++;
                    $display("FAIL hold_stable: got valid=%b x=%0d y=%0d, required held x=%0d y=%0d",
                             rif.valid, rif.x, rif.y, prev_ray[116:106], prev_ray[105:96]);
                end
            end
            if (rif.valid && rif.ready) begin
                obs_x.push_back(int'(rif.x));
                obs_y.push_back(int'(rif.y));
                obs_dx.push_back(rif.dir_x);
                obs_dy.push_back(rif.dir_y);
                obs_dz.push_back(rif.dir_z);
                $display("ray x=%0d y=%0d dx=%h dy=%h dz=%h", rif.x, rif.y, rif.dir_x, rif.dir_y, rif.dir_z);
            end
            stall_prev = rif.valid && !rif.ready;
            prev_ray   = {rif.x, rif.y, rif.dir_x, rif.dir_y, rif.dir_z};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_x.delete(); obs_y.delete(); obs_dx.delete(); obs_dy.delete(); obs_dz.delete();
        pix_cnt  = 0;
        done_cnt = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_frame(input string name, input int budget);
        int n = 0;
        while ((done_cnt == 0 || busy_out) && n < budget) begin tick(); n++; end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout: frame not done after %0d cycles (done=%0d busy=%b)", name, n, done_cnt, busy_out);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rif.ready = 1'b0; inj = 1'b0;
        tick(); tick();
        checks++;
        if ({busy_out, frame_done_out, pix_valid_out, rif.valid, ovf_err_out} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 00000",
                     {busy_out, frame_done_out, pix_valid_out, rif.valid, ovf_err_out});
        end
        checks++;
        if ({pix_x_out, pix_y_out, rif.x, rif.y} !== 42'd0) begin
            errors++;
            $display("FAIL reset_coords: pix=(%0d,%0d) ray=(%0d,%0d) required zeros", pix_x_out, pix_y_out, rif.x, rif.y);
        end
        checks++;
        if ({rif.dir_x, rif.dir_y, rif.dir_z} !== 96'd0) begin
            errors++;
            $display("FAIL reset_dirs: got %h %h %h required 0", rif.dir_x, rif.dir_y, rif.dir_z);
        end
        rst = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_basic();
        clear_obs();
        rif.ready = 1'b1;
        pulse_start();
        checks++;
        if ({pix_valid_out, pix_x_out, pix_y_out} !== {1'b1, 11'd0, 10'd0}) begin
            errors++;
            $display("FAIL first_issue: got v=%b (%0d,%0d) required v=1 (0,0)", pix_valid_out, pix_x_out, pix_y_out);
        end
        tick();
        checks++;
        if ({pix_valid_out, pix_x_out, pix_y_out} !== {1'b1, 11'd1, 10'd0}) begin
            errors++;
            $display("FAIL second_issue: got v=%b (%0d,%0d) required v=1 (1,0)", pix_valid_out, pix_x_out, pix_y_out);
        end
        wait_frame("basic", 200);
        checks++;
        if (obs_x.size() != W * H) begin
            errors++;
            $display("FAIL basic_count: got %0d rays required %0d", obs_x.size(), W * H);
        end
        for (int k = 0; k < obs_x.size() && k < W * H; k++) begin
            checks++;
            if (obs_x[k] != k % W || obs_y[k] != k / W || obs_dx[k] !== fbits(k % W) ||
                obs_dy[k] !== fbits(k / W) || obs_dz[k] !== dirz(k % W, k / W)) begin
                errors++;
                $display("FAIL basic_ray%0d: got (%0d,%0d) dx=%h dz=%h required (%0d,%0d) dx=%h dz=%h", k,
                         obs_x[k], obs_y[k], obs_dx[k], obs_dz[k], k % W, k / W, fbits(k % W), dirz(k % W, k / W));
            end
        end
        tick();
        checks++;
        if (done_cnt != 1 || frame_done_out !== 1'b0 || busy_out !== 1'b0 || ovf_err_out !== 1'b0 || pix_cnt != 8) begin
            errors++;
            $display("FAIL basic_end: done=%0d fd=%b busy=%b ovf=%b pix=%0d required 1 0 0 0 8",
                     done_cnt, frame_done_out, busy_out, ovf_err_out, pix_cnt);
        end
    endtask

    task automatic test_stall();
        clear_obs();
        rif.ready = 1'b0;
        pulse_start();
        repeat (30) tick();
        checks++;
        if (pix_cnt != C || rif.valid !== 1'b1 || busy_out !== 1'b1 || obs_x.size() != 0) begin
            errors++;
            $display("FAIL stall_credits: pix=%0d valid=%b busy=%b rays=%0d required %0d 1 1 0",
                     pix_cnt, rif.valid, busy_out, obs_x.size(), C);
        end
        rif.ready = 1'b1;
        wait_frame("stall", 200);
        checks++;
        if (obs_x.size() != W * H || pix_cnt != W * H || done_cnt != 1 || ovf_err_out !== 1'b0) begin
            errors++;
            $display("FAIL stall_resume: rays=%0d pix=%0d done=%0d ovf=%b required 8 8 1 0",
                     obs_x.size(), pix_cnt, done_cnt, ovf_err_out);
        end
        for (int k = 0; k < obs_x.size() && k < W * H; k++) begin
            checks++;
            if (obs_x[k] != k % W || obs_y[k] != k / W || obs_dx[k] !== fbits(k % W)) begin
                errors++;
                $display("FAIL stall_ray%0d: got (%0d,%0d) dx=%h required (%0d,%0d)", k,
                         obs_x[k], obs_y[k], obs_dx[k], k % W, k / W);
            end
        end
    endtask

    task automatic test_hold();
        int n = 0;
        int s0;
        bit held = 1'b0;
        clear_obs();
        s0 = stall_checks;
        rif.ready = 1'b1;
        pulse_start();
        while ((done_cnt == 0 || busy_out) && n < 300) begin
            if (!held && rif.valid && rif.x == 11'd2 && rif.y == 10'd0) begin
                rif.ready = 1'b0;
                repeat (3) tick();
                rif.ready = 1'b1;
                held = 1'b1;
            end
            tick();
            n++;
        end
        checks++;
        if (n >= 300 || !held || stall_checks - s0 < 3) begin
            errors++;
            $display("FAIL hold_scenario: cycles=%0d held=%b stall_checks=%0d required done,1,>=3",
                     n, held, stall_checks - s0);
        end
        checks++;
        if (obs_x.size() != W * H) begin
            errors++;
            $display("FAIL hold_count: got %0d rays required %0d", obs_x.size(), W * H);
        end
        for (int k = 0; k < obs_x.size() && k < W * H; k++) begin
            checks++;
            if (obs_x[k] != k % W || obs_y[k] != k / W || obs_dz[k] !== dirz(k % W, k / W)) begin
                errors++;
                $display("FAIL hold_ray%0d: got (%0d,%0d) required (%0d,%0d)", k, obs_x[k], obs_y[k], k % W, k / W);
            end
        end
    endtask

    task automatic test_restart_ignored();
        clear_obs();
        rif.ready = 1'b1;
        pulse_start();
        tick(); tick();
        pulse_start();
        tick();
        pulse_start();
        wait_frame("restart", 200);
        repeat (25) tick();
        checks++;
        if (obs_x.size() != W * H || done_cnt != 1 || pix_cnt != W * H || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL restart_ignored: rays=%0d done=%0d pix=%0d busy=%b required 8 1 8 0",
                     obs_x.size(), done_cnt, pix_cnt, busy_out);
        end
    endtask

    task automatic test_random_ready();
        for (int f = 0; f < 3; f++) begin
            int n = 0;
            clear_obs();
            repeat ($urandom_range(0, 3)) tick();
            pulse_start();
            while ((done_cnt == 0 || busy_out) && n < 600) begin
                rif.ready = 1'($urandom_range(0, 1));
                tick();
                n++;
            end
            rif.ready = 1'b1;
            checks++;
            if (n >= 600 || obs_x.size() != W * H || done_cnt != 1 || ovf_err_out !== 1'b0) begin
                errors++;
                $display("FAIL random%0d_frame: cycles=%0d rays=%0d done=%0d ovf=%b required 8 1 0",
                         f, n, obs_x.size(), done_cnt, ovf_err_out);
            end
            for (int k = 0; k < obs_x.size() && k < W * H; k++) begin
                checks++;
                if (obs_x[k] != k % W || obs_y[k] != k / W || obs_dx[k] !== fbits(k % W) || obs_dy[k] !== fbits(k / W))
                    begin
                    errors++;
                    $display("FAIL random%0d_ray%0d: got (%0d,%0d) required (%0d,%0d)", f, k,
                             obs_x[k], obs_y[k], k % W, k / W);
                end
            end
        end
    endtask

    task automatic test_midframe_reset();
        int n = 0;
        clear_obs();
        rif.ready = 1'b1;
        pulse_start();
        while (pix_cnt < 3 && n < 50) begin tick(); n++; end
        rst = 1'b1;
        tick();
        checks++;
        if ({busy_out, frame_done_out, pix_valid_out, rif.valid, ovf_err_out, pix_x_out, pix_y_out, rif.x, rif.y} !== 47'd0)
            begin
            errors++;
            $display("FAIL midreset_outputs: busy=%b fd=%b pv=%b rv=%b ovf=%b pix=(%0d,%0d) ray=(%0d,%0d) required zeros",
                     busy_out, frame_done_out, pix_valid_out, rif.valid, ovf_err_out, pix_x_out, pix_y_out, rif.x, rif.y);
        end
        rst = 1'b0;
        repeat (15) tick();
        checks++;
        if ({busy_out, rif.valid, ovf_err_out, pix_valid_out} !== 4'b0) begin
            errors++;
            $display("FAIL midreset_idle: busy=%b rv=%b ovf=%b pv=%b required 0000",
                     busy_out, rif.valid, ovf_err_out, pix_valid_out);
        end
        clear_obs();
        pulse_start();
        wait_frame("midreset", 200);
        checks++;
        if (obs_x.size() != W * H || done_cnt != 1 || ovf_err_out !== 1'b0) begin
            errors++;
            $display("FAIL midreset_frame: rays=%0d done=%0d ovf=%b required 8 1 0", obs_x.size(), done_cnt, ovf_err_out);
        end
        for (int k = 0; k < obs_x.size() && k < W * H; k++) begin
            checks++;
            if (obs_x[k] != k % W || obs_y[k] != k / W) begin
                errors++;
                $display("FAIL midreset_ray%0d: got (%0d,%0d) required (%0d,%0d)", k, obs_x[k], obs_y[k], k % W, k / W);
            end
        end
    endtask

    task automatic test_stray_result();
        clear_obs();
        tick();
        inj = 1'b1;
        tick();
        inj = 1'b0;
        repeat (5) tick();
        checks++;
        if (ovf_err_out !== 1'b1 || rif.valid !== 1'b0 || obs_x.size() != 0) begin
            errors++;
            $display("FAIL stray_flag: ovf=%b rv=%b rays=%0d required 1 0 0", ovf_err_out, rif.valid, obs_x.size());
        end
        repeat (10) tick();
        checks++;
        if (ovf_err_out !== 1'b1) begin
            errors++;
            $display("FAIL stray_sticky: ovf=%b required 1", ovf_err_out);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (ovf_err_out !== 1'b0) begin
            errors++;
            $display("FAIL stray_clear: ovf=%b required 0", ovf_err_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_hold();
        test_restart_ignored();
        test_random_ready();
        test_midframe_reset();
        test_stray_result();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
